wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback arbiter in front of the register file's single write port.
- Merges two result streams into one registered write per cycle:
  - the single-cycle ALU result path, which has priority;
  - the long-latency memory/load path, buffered in an internal FIFO.
- Applies anti-starvation for the memory path and drops writes to register 0.
- Drives the register file's w_enable / w_addr / w_data inputs directly.

Parameters:
- MEM_FIFO_DEPTH, 4, memory-path FIFO entries; power of two, >= 2.
- STARVE_LIMIT, 3, consecutive cycles a non-empty memory FIFO may lose to the ALU before it is forced through; >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid && alu_ready.
- alu_rd  in  5 (regid_t)  ALU destination register.
- alu_data  in  32 (word_t)  ALU result.
- mem_valid  in  1  memory result valid.
- mem_ready  out  1  memory FIFO can accept; transfer when mem_valid && mem_ready.
- mem_rd  in  5 (regid_t)  memory destination register.
- mem_data  in  32 (word_t)  memory result.
- rf_w_enable  out  1  register-file write enable.
- rf_w_addr  out  5 (regid_t)  register-file write address.
- rf_w_data  out  32 (word_t)  register-file write data.
- mem_fifo_count  out  $clog2(MEM_FIFO_DEPTH)+1  current FIFO occupancy.
- wb_idle  out  1  FIFO empty and no write issued this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO emptied; starvation counter = 0.
  - rf_w_enable=0, rf_w_addr=0, rf_w_data=0.
  - While rst is high: alu_ready=0 and mem_ready=0, combinationally gated.
  - Reset mid-operation discards all buffered memory results, with no write for them.
- mem_ready = !rst && (count < MEM_FIFO_DEPTH). No same-cycle pass-through when full: a full FIFO deasserts mem_ready even if it pops that cycle.
- Push: on mem_valid && mem_ready, {mem_rd, mem_data} is written at the tail. An entry pushed in cycle N is eligible for pop from cycle N+1.
- force_mem = (count != 0) && (starve_cnt >= STARVE_LIMIT).
- Grant each cycle, in priority order:
  1. force_mem -> pop FIFO head; alu_ready=0.
  2. else alu_valid -> take ALU; alu_ready=1.
  3. else count != 0 -> pop FIFO head.
  4. else idle.
- alu_ready = !rst && !force_mem. It does not depend on alu_valid.
- Starvation counter:
  - increments, saturating at STARVE_LIMIT, when count != 0 and the ALU is granted;
  - cleared to 0 on any FIFO pop or when count == 0.
- Output register, 1-cycle latency (a grant in cycle N gives a write at edge N+1):
  - on a grant: rf_w_addr/rf_w_data <= granted rd/data, and rf_w_enable <= (granted rd != 0);
  - no grant: rf_w_enable <= 0, rf_w_addr/rf_w_data hold.
  - Writes to rd=0 are consumed (handshake completes, pop occurs) but never enabled.
- Simultaneous push and pop: count is unchanged, and the pointers advance independently and wrap modulo MEM_FIFO_DEPTH.
- Ordering:
  - The memory stream is strictly FIFO.
  - There is no ordering between the ALU and memory streams; same-rd ordering across streams is the issuer's responsibility.
- wb_idle = (count == 0) && !rf_w_enable.

Test Plan:
- Reset: hold rst 2 cycles with both valids high -> alu_ready=0, mem_ready=0, rf_w_enable=0, count=0. After release: mem_ready=1, alu_ready=1.
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF in cycle N -> at edge N+1, rf_w_enable=1, addr=5, data=0xDEADBEEF. Next cycle with alu_valid=0 -> rf_w_enable=0.
- Register 0: ALU rd=0, data=0x1234, then mem rd=0 -> both handshakes complete, rf_w_enable never asserts, FIFO drains to 0.
- FIFO full: push 4 memory results (rd 1..4, data 0x10..0x40) while alu_valid stays high -> mem_ready=0 at count=4. ALU wins 3 cycles, then the 4th cycle is forced: alu_ready=0, write rd=1/0x10. Remaining entries drain in order 2,3,4 under the same 3:1 pattern.
- Drain: alu_valid=0 with 3 entries buffered -> 3 consecutive writes in FIFO order, count 3->0, then wb_idle=1.
- Wrap and concurrent push/pop: stream 10 memory results back-to-back with no ALU traffic -> count stays <=1, all 10 writes arrive in order, each 2 cycles after its push. Assert rst mid-stream -> buffered entries are lost and no further writes occur.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter bus: ALU/memory result streams in, register-file write port out
//   alu_valid/alu_ready/alu_rd/alu_data : single-cycle ALU result handshake
//   mem_valid/mem_ready/mem_rd/mem_data : memory/load result handshake (buffered)
//   rf_w_enable/rf_w_addr/rf_w_data     : register-file write port
//   mem_fifo_count                      : memory FIFO occupancy
//   wb_idle                             : nothing buffered and no write this cycle
//   modport master : result producers / register-file side (bench)
//   modport slave  : the arbiter
interface wb_arbiter_if #(
  parameter int MEM_FIFO_DEPTH = 4
);
  localparam int CW = $clog2(MEM_FIFO_DEPTH) + 1;

  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_rd;
  logic [31:0]   mem_data;
  logic          rf_w_enable;
  logic [4:0]    rf_w_addr;
  logic [31:0]   rf_w_data;
  logic [CW-1:0] mem_fifo_count;
  logic          wb_idle;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready,
    input  rf_w_enable, rf_w_addr, rf_w_data,
    input  mem_fifo_count, wb_idle
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready,
    output rf_w_enable, rf_w_addr, rf_w_data,
    output mem_fifo_count, wb_idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: ALU priority, buffered memory path, anti-starvation, r0 drop
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : wb_arbiter_if.slave (ALU/memory result streams, register-file write port, status)
module wb_arbiter #(
  parameter int MEM_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(MEM_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(MEM_FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [4:0]    fifo_rd_q   [MEM_FIFO_DEPTH];
  logic [31:0]   fifo_data_q [MEM_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          w_en_q, w_en_d;
  logic [4:0]    w_addr_q, w_addr_d;
  logic [31:0]   w_data_q, w_data_d;

  logic fifo_nempty;
  logic force_mem;
  logic push;
  logic alu_take;
  logic pop;

  assign fifo_nempty = (count_q != '0);
  assign force_mem   = fifo_nempty && (starve_q >= LIMIT_C);

  // Ready signals depend only on state and reset, never on the valids.
  // A full FIFO refuses a push even if it pops in the same cycle.
  assign bus.alu_ready = !rst && !force_mem;
  assign bus.mem_ready = !rst && (count_q < DEPTH_C);

  assign push     = bus.mem_valid && bus.mem_ready;
  assign alu_take = bus.alu_valid && bus.alu_ready;
  // Forced grants already block the ALU via alu_ready, so the FIFO pops
  // whenever it holds data and the ALU did not win.
  assign pop      = !rst && fifo_nempty && !alu_take;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    starve_d = starve_q;
    if (!fifo_nempty || pop) begin
      starve_d = '0;
    end else if (alu_take && (starve_q < LIMIT_C)) begin
      starve_d = starve_q + SW'(1);
    end

    // Address/data hold when nothing is granted; r0 writes are consumed
    // but never enabled.
    w_en_d   = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (alu_take) begin
      w_en_d   = (bus.alu_rd != 5'd0);
      w_addr_d = bus.alu_rd;
      w_data_d = bus.alu_data;
    end else if (pop) begin
      w_en_d   = (fifo_rd_q[rd_ptr_q] != 5'd0);
      w_addr_d = fifo_rd_q[rd_ptr_q];
      w_data_d = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.mem_rd;
      fifo_data_q[wr_ptr_q] <= bus.mem_data;
    end
  end

  assign bus.rf_w_enable    = w_en_q;
  assign bus.rf_w_addr      = w_addr_q;
  assign bus.rf_w_data      = w_data_q;
  assign bus.mem_fifo_count = count_q;
  assign bus.wb_idle        = (count_q == '0) && !w_en_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic frc;
  int   exp_addr;
  int   exp_data;
  int   exp_cnt;

  wb_arbiter_if #(.MEM_FIFO_DEPTH(4)) bus ();

  wb_arbiter #(
    .MEM_FIFO_DEPTH(4),
    .STARVE_LIMIT  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'h1111_1111;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd4;
    bus.mem_data  = 32'h2222_2222;

    // Reset held two cycles with both valids high
    #1;
    check("rst_alu_ready", bus.alu_ready, 0);
    check("rst_mem_ready", bus.mem_ready, 0);
    tick;
    tick;
    check("rst_alu_ready2", bus.alu_ready, 0);
    check("rst_mem_ready2", bus.mem_ready, 0);
    check("rst_w_enable", bus.rf_w_enable, 0);
    check("rst_w_addr", bus.rf_w_addr, 0);
    check("rst_w_data", bus.rf_w_data, 0);
    check("rst_count", bus.mem_fifo_count, 0);
    rst = 1'b0;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    check("post_rst_mem_ready", bus.mem_ready, 1);
    check("post_rst_alu_ready", bus.alu_ready, 1);
    check("post_rst_idle", bus.wb_idle, 1);

    // ALU only
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEAD_BEEF;
    tick;
    check("alu_w_enable", bus.rf_w_enable, 1);
    check("alu_w_addr", bus.rf_w_addr, 5);
    check("alu_w_data", bus.rf_w_data, 32'hDEAD_BEEF);
    check("alu_idle", bus.wb_idle, 0);
    bus.alu_valid = 1'b0;
    tick;
    check("alu_off_w_enable", bus.rf_w_enable, 0);
    check("alu_off_hold_addr", bus.rf_w_addr, 5);
    check("alu_off_idle", bus.wb_idle, 1);

    // Register 0 on both paths: consumed but never written
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h0000_1234;
    check("r0_alu_ready", bus.alu_ready, 1);
    tick;
    check("r0_alu_w_enable", bus.rf_w_enable, 0);
    check("r0_alu_w_data", bus.rf_w_data, 32'h0000_1234);
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd0;
    bus.mem_data  = 32'h0000_0055;
    check("r0_mem_ready", bus.mem_ready, 1);
    tick;
    check("r0_mem_push_count", bus.mem_fifo_count, 1);
    check("r0_mem_push_w_enable", bus.rf_w_enable, 0);
    bus.mem_valid = 1'b0;
    tick;
    check("r0_mem_pop_w_enable", bus.rf_w_enable, 0);
    check("r0_mem_pop_count", bus.mem_fifo_count, 0);
    check("r0_mem_pop_w_data", bus.rf_w_data, 32'h0000_0055);
    check("r0_idle", bus.wb_idle, 1);

    // FIFO full under constant ALU pressure: 3 ALU wins then one forced pop
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd7;
    for (int c = 0; c < 17; c++) begin
      frc = (c >= 4) && (c % 4 == 0);
      bus.alu_data  = 32'h1000 + c;
      bus.mem_valid = (c <= 4);
      bus.mem_rd    = 5'(c + 1);
      bus.mem_data  = 32'((c + 1) * 16);
      check($sformatf("full_alu_ready_c%0d", c), bus.alu_ready, !frc);
      if (c <= 4) check($sformatf("full_mem_ready_c%0d", c), bus.mem_ready, (c < 4));
      tick;
      exp_addr = frc ? c / 4 : 7;
      exp_data = frc ? (c / 4) * 16 : 32'h1000 + c;
      exp_cnt  = (c < 4) ? c + 1 : 4 - c / 4;
      check($sformatf("full_w_enable_c%0d", c), bus.rf_w_enable, 1);
      check($sformatf("full_w_addr_c%0d", c), bus.rf_w_addr, exp_addr);
      check($sformatf("full_w_data_c%0d", c), bus.rf_w_data, exp_data);
      check($sformatf("full_count_c%0d", c), bus.mem_fifo_count, exp_cnt);
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    tick;
    check("full_end_w_enable", bus.rf_w_enable, 0);
    check("full_end_idle", bus.wb_idle, 1);

    // Drain: buffer 3 entries behind the ALU, then release
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd8;
    bus.mem_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.alu_data = 32'h800 + c;
      bus.mem_rd   = 5'(11 + c);
      bus.mem_data = 32'hA1 + c;
      tick;
      check($sformatf("fill_w_addr_c%0d", c), bus.rf_w_addr, 8);
      check($sformatf("fill_count_c%0d", c), bus.mem_fifo_count, c + 1);
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      tick;
      check($sformatf("drain_w_enable_d%0d", d), bus.rf_w_enable, 1);
      check($sformatf("drain_w_addr_d%0d", d), bus.rf_w_addr, 11 + d);
      check($sformatf("drain_w_data_d%0d", d), bus.rf_w_data, 32'hA1 + d);
      check($sformatf("drain_count_d%0d", d), bus.mem_fifo_count, 2 - d);
    end
    check("drain_last_idle", bus.wb_idle, 0);
    tick;
    check("drain_done_w_enable", bus.rf_w_enable, 0);
    check("drain_done_idle", bus.wb_idle, 1);

    // Back-to-back memory stream across pointer wrap, then reset mid-stream
    bus.mem_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.mem_rd   = 5'(k + 1);
      bus.mem_data = 32'h200 + k;
      check($sformatf("wrap_mem_ready_k%0d", k), bus.mem_ready, 1);
      tick;
      check($sformatf("wrap_count_k%0d", k), bus.mem_fifo_count, 1);
      check($sformatf("wrap_w_enable_k%0d", k), bus.rf_w_enable, (k != 0));
      if (k != 0) begin
        check($sformatf("wrap_w_addr_k%0d", k), bus.rf_w_addr, k);
        check($sformatf("wrap_w_data_k%0d", k), bus.rf_w_data, 32'h200 + k - 1);
      end
    end
    rst = 1'b1;
    bus.mem_rd   = 5'd11;
    bus.mem_data = 32'h2AA;
    #1;
    check("midrst_mem_ready", bus.mem_ready, 0);
    check("midrst_alu_ready", bus.alu_ready, 0);
    tick;
    check("midrst_w_enable", bus.rf_w_enable, 0);
    check("midrst_count", bus.mem_fifo_count, 0);
    check("midrst_w_addr", bus.rf_w_addr, 0);
    rst = 1'b0;
    bus.mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("after_rst_w_enable_%0d", i), bus.rf_w_enable, 0);
      check($sformatf("after_rst_idle_%0d", i), bus.wb_idle, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
